pll_reset_sequencer: RTL and testbench

- Supervises the board PLL, running entirely in the 50 MHz reference-clock domain.
- Drives the PLL reset, qualifies the asynchronous `locked` flag, and releases per-clock-domain core resets in a fixed staggered order.
- On lock loss, software restart or lock timeout, forces the whole core back into reset and re-runs the sequence.
- Sits between the top-level reset input and the PLL / core reset tree.

---
 rtl/pll_ctrl_pkg.sv | 17 +
 rtl/sync_2ff.sv | 19 +
 rtl/pll_reset_sequencer.sv | 87 ++++++++
 tb/tb_pll_reset_sequencer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: sequencer state encodings, relock limit and default timing constants
package pll_ctrl_pkg;
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } pll_state_t;
  localparam int RELOCK_MAX = 255;
  localparam int DEF_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT = 500000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_STAGGER = 8;
  localparam int DEF_NUM_DOMAINS = 3;
  localparam int DEF_CNT_W = 20;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer with synchronous reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset, lock qualification and staggered per-domain reset release
module pll_reset_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int STAGGER       = DEF_STAGGER,
  parameter int NUM_DOMAINS   = DEF_NUM_DOMAINS,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  input  logic                   restart,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   ready,
  output logic [2:0]             state,
  output logic [7:0]             relock_cnt,
  output logic                   timeout_err
);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  pll_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d, rel_hit;
  logic [7:0] relock_cnt_q, relock_cnt_d;
  logic pll_rst_q, pll_rst_d, ready_q, ready_d, timeout_err_q, timeout_err_d;
  logic locked_s, lock_loss, timeout_hit;
  sync_2ff u_lock_sync (
    .clk(refclk),
    .rst(rst),
    .d  (locked),
    .q  (locked_s)
  );
  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_rel
    assign rel_hit[i] = state_q == RELEASE && cnt_q == CNT_W'((i + 1) * STAGGER - 1);
  end
  always_comb begin
    lock_loss = !locked_s && (state_q == RELEASE || state_q == RUN);
    timeout_hit = state_q == WAIT_LOCK && !locked_s && cnt_q == TIMEOUT_LAST;
    state_d = state_q;
    case (state_q)
      RESET_PLL: state_d = cnt_q == RST_LAST ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: state_d = locked_s ? STABLE : timeout_hit ? RESET_PLL : WAIT_LOCK;
      STABLE:    state_d = !locked_s ? WAIT_LOCK : cnt_q == STABLE_LAST ? RELEASE : STABLE;
      RELEASE:   state_d = lock_loss ? RESET_PLL : dom_rst_q == '0 ? RUN : RELEASE;
      RUN:       state_d = lock_loss ? RESET_PLL : RUN;
      default:   state_d = RESET_PLL;
    endcase
    if (restart) state_d = RESET_PLL;
    cnt_d = (state_d != state_q || restart) ? '0 : cnt_q + CNT_W'(1);
    pll_rst_d = state_d == RESET_PLL;
    ready_d = state_d == RUN;
    dom_rst_d = state_d == RESET_PLL ? '1 : dom_rst_q & ~rel_hit;
    relock_cnt_d = (lock_loss || (timeout_hit && !restart)) && relock_cnt_q != 8'(RELOCK_MAX)
                   ? relock_cnt_q + 8'd1 : relock_cnt_q;
    timeout_err_d = restart ? 1'b0 : timeout_hit ? 1'b1 : timeout_err_q;
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      pll_rst_q     <= 1'b1;
      dom_rst_q     <= '1;
      ready_q       <= 1'b0;
      relock_cnt_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pll_rst_q     <= pll_rst_d;
      dom_rst_q     <= dom_rst_d;
      ready_q       <= ready_d;
      relock_cnt_q  <= relock_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign pll_rst = pll_rst_q;
  assign dom_rst = dom_rst_q;
  assign ready = ready_q;
  assign state = state_q;
  assign relock_cnt = relock_cnt_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed stimulus with a cycle-scheduled scoreboard for pll_reset_sequencer
module tb_pll_reset_sequencer;
  logic refclk = 1'b0;
  logic rst = 1'b1, locked = 1'b0, restart = 1'b0;
  logic pll_rst, ready, timeout_err;
  logic [2:0] dom_rst, state;
  logic [7:0] relock_cnt;
  typedef struct {
    int         cyc;
    string      name;
    logic [2:0] st;
    logic [2:0] dom;
    logic [7:0] rc;
    logic       te;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  always #10 refclk = ~refclk;
  pll_reset_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(16),
    .STAGGER(2), .NUM_DOMAINS(3), .CNT_W(20)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .restart(restart),
    .pll_rst(pll_rst), .dom_rst(dom_rst), .ready(ready), .state(state),
    .relock_cnt(relock_cnt), .timeout_err(timeout_err)
  );
  task automatic ex(input int c, input string name, input logic [2:0] st, input logic [2:0] dom,
                    input logic [7:0] rc, input logic te);
    exp_t e;
    e.cyc = c;
    e.name = name;
    e.st = st;
    e.dom = dom;
    e.rc = rc;
    e.te = te;
    q.push_back(e);
  endtask
  task automatic tick_to(input int c);
    while (cyc < c) @(negedge refclk);
  endtask
  task automatic do_reset(input logic lk, output int base);
    @(negedge refclk);
    rst = 1'b1;
    locked = lk;
    restart = 1'b0;
    ex(cyc + 1, "reset_state", 0, 3'b111, 0, 0);
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    base = cyc;
  endtask
  initial forever begin
    @(posedge refclk);
    cyc++;
    #2;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s: scheduled for cycle %0d but reached at cycle %0d", e.name, e.cyc, cyc);
      end else if ({state, dom_rst, relock_cnt, timeout_err, pll_rst, ready} !==
                   {e.st, e.dom, e.rc, e.te, e.st == 3'd0, e.st == 3'd4}) begin
        n_fail++;
        $display("FAIL %s @%0d: got st=%0d dom=%b rc=%0d te=%b pll=%b rdy=%b, expected st=%0d dom=%b rc=%0d te=%b pll=%b rdy=%b",
                 e.name, cyc, state, dom_rst, relock_cnt, timeout_err, pll_rst, ready,
                 e.st, e.dom, e.rc, e.te, e.st == 3'd0, e.st == 3'd4);
      end
    end
  end
  initial begin
    int r, x;
    do_reset(1'b0, r);
    ex(r + 3, "p1_pll_held", 0, 3'b111, 0, 0);
    ex(r + 4, "p1_wait_lock", 1, 3'b111, 0, 0);
    ex(r + 12, "p1_sync_lat", 1, 3'b111, 0, 0);
    ex(r + 13, "p1_stable", 2, 3'b111, 0, 0);
    ex(r + 28, "p1_stable_end", 2, 3'b111, 0, 0);
    ex(r + 29, "p1_release", 3, 3'b111, 0, 0);
    ex(r + 30, "p1_rel_c0", 3, 3'b111, 0, 0);
    ex(r + 31, "p1_dom0", 3, 3'b110, 0, 0);
    ex(r + 32, "p1_dom0_hold", 3, 3'b110, 0, 0);
    ex(r + 33, "p1_dom1", 3, 3'b100, 0, 0);
    ex(r + 35, "p1_dom2", 3, 3'b000, 0, 0);
    ex(r + 36, "p1_run", 4, 3'b000, 0, 0);
    tick_to(r + 10);
    locked = 1'b1;
    ex(r + 42, "p2_run_pre", 4, 3'b000, 0, 0);
    ex(r + 43, "p2_lock_loss", 0, 3'b111, 1, 0);
    ex(r + 47, "p2_rewait", 1, 3'b111, 1, 0);
    ex(r + 48, "p2_restable", 2, 3'b111, 1, 0);
    ex(r + 64, "p2_rerelease", 3, 3'b111, 1, 0);
    ex(r + 71, "p2_rerun", 4, 3'b000, 1, 0);
    tick_to(r + 40);
    locked = 1'b0;
    tick_to(r + 41);
    locked = 1'b1;
    tick_to(r + 71);
    do_reset(1'b0, r);
    ex(r + 3, "p3_pll_held", 0, 3'b111, 0, 0);
    ex(r + 4, "p3_wait", 1, 3'b111, 0, 0);
    ex(r + 67, "p3_pre_timeout", 1, 3'b111, 0, 0);
    ex(r + 68, "p3_timeout1", 0, 3'b111, 1, 1);
    ex(r + 71, "p3_pll_reheld", 0, 3'b111, 1, 1);
    ex(r + 72, "p3_rewait", 1, 3'b111, 1, 1);
    ex(r + 135, "p3_pre_timeout2", 1, 3'b111, 1, 1);
    ex(r + 136, "p3_timeout2", 0, 3'b111, 2, 1);
    ex(r + 204, "p3_timeout3", 0, 3'b111, 3, 1);
    tick_to(r + 204);
    locked = 1'b1;
    ex(r + 208, "p4_wait", 1, 3'b111, 3, 1);
    ex(r + 209, "p4_stable", 2, 3'b111, 3, 1);
    ex(r + 225, "p4_release", 3, 3'b111, 3, 1);
    ex(r + 227, "p4_dom0", 3, 3'b110, 3, 1);
    ex(r + 231, "p4_dom2", 3, 3'b000, 3, 1);
    ex(r + 232, "p4_run_te", 4, 3'b000, 3, 1);
    ex(r + 235, "p4_pre_restart", 4, 3'b000, 3, 1);
    ex(r + 236, "p4_restart", 0, 3'b111, 3, 0);
    ex(r + 264, "p4_rerun", 4, 3'b000, 3, 0);
    ex(r + 272, "p4_pre_loss", 4, 3'b000, 3, 0);
    ex(r + 273, "p4_restart_loss", 0, 3'b111, 4, 0);
    tick_to(r + 235);
    restart = 1'b1;
    tick_to(r + 236);
    restart = 1'b0;
    tick_to(r + 270);
    locked = 1'b0;
    tick_to(r + 272);
    restart = 1'b1;
    tick_to(r + 273);
    restart = 1'b0;
    do_reset(1'b1, r);
    ex(r + 13, "p5_stable_c8", 2, 3'b111, 0, 0);
    ex(r + 14, "p5_glitch", 1, 3'b111, 0, 0);
    ex(r + 15, "p5_restable", 2, 3'b111, 0, 0);
    ex(r + 30, "p5_delayed", 2, 3'b111, 0, 0);
    ex(r + 31, "p5_release", 3, 3'b111, 0, 0);
    tick_to(r + 11);
    locked = 1'b0;
    tick_to(r + 12);
    locked = 1'b1;
    tick_to(r + 31);
    do_reset(1'b1, r);
    ex(r + 28, "p6_run", 4, 3'b000, 0, 0);
    x = r + 30;
    for (int k = 1; k <= 300; k++) begin
      x = r + 30 + (k - 1) * 40;
      tick_to(x);
      locked = 1'b0;
      ex(x + 3, $sformatf("p6_loss%0d", k), 0, 3'b111, 8'(k > 255 ? 255 : k), 0);
      tick_to(x + 1);
      locked = 1'b1;
    end
    ex(x + 24, "p7_release", 3, 3'b111, 255, 0);
    ex(x + 26, "p7_mid_release", 3, 3'b110, 255, 0);
    ex(x + 27, "p7_rst_mid", 0, 3'b111, 0, 0);
    tick_to(x + 26);
    rst = 1'b1;
    tick_to(x + 27);
    rst = 1'b0;
    ex(x + 28, "p7_after_rst", 0, 3'b111, 0, 0);
    tick_to(x + 30);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d checks left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
